// File: rtl/lanes_sched_pkg.sv
// Shared types and constants for the two-lane symbol scheduler.
// Generation encodings, symbol lengths and the idle symbol live here.
package lanes_sched_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam logic [1:0] GEN4     = 2'b00;
    localparam logic [1:0] GEN2     = 2'b01;
    localparam logic [1:0] GEN3     = 2'b10;
    localparam logic [1:0] GEN_RSVD = 2'b11;

    localparam logic [7:0] GEN2_LEN  = 8'd66;
    localparam logic [7:0] GEN34_LEN = 8'd132;

    localparam int SYM_MAX = 132;
    localparam logic [SYM_MAX-1:0] IDLE_SYM = '0;

    // Reserved speed runs at the long symbol length; the error flag is raised elsewhere.
    function automatic logic [7:0] sym_len(input logic [1:0] gen);
        logic [7:0] len;
        case (gen)
            GEN2:                  len = GEN2_LEN;
            GEN3, GEN4, GEN_RSVD:  len = GEN34_LEN;
            default:               len = GEN34_LEN;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/lanes_sym_fifo.sv
// Two-entry FIFO holding lane-pair symbols between the encoder and the scheduler.
// ready is registered and reports not-full after the current edge.
module lanes_sym_fifo #(
    parameter int DW = 264
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          ready
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [1:0]    count_next;

    assign count_next = count + {1'b0, push} - {1'b0, pop};

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            ready  <= 1'b1;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count_next;
            ready <= (count_next != 2'd2);
        end
    end

    // NOTE: storage is not reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == 2'd0);

endmodule

// File: rtl/lanes_tx_rx_sched.sv
// Symbol scheduler and enable sequencer for the two-lane serializer/deserializer.
// Loads symbols at boundaries, inserts idles on underrun, drains on stop or speed change.
module lanes_tx_rx_sched
    import lanes_sched_pkg::*;
#(
    parameter int WIDTH      = 132,
    parameter int UNDERRUN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  link_en,
    input  logic [1:0]            gen_speed,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_lane_0,
    input  logic [WIDTH-1:0]      in_lane_1,
    output logic                  enable_ser,
    output logic                  enable_deser,
    output logic [WIDTH-1:0]      lane_0_tx_parallel,
    output logic [WIDTH-1:0]      lane_1_tx_parallel,
    output logic                  sym_tick,
    output logic [1:0]            active_gen,
    output logic                  gen_err,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    state_e             state;
    state_e             state_next;
    logic [7:0]         bit_cnt;
    logic               last_bit;
    logic               counting;
    logic               load;
    logic [1:0]         load_gen;
    logic [WIDTH-1:0]   sym_mask;
    logic [2*WIDTH-1:0] head;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   next_0;
    logic [WIDTH-1:0]   next_1;

    assign counting = (state == ST_RUN) || (state == ST_DRAIN);
    assign last_bit = counting && (bit_cnt == sym_len(active_gen) - 8'd1);
    assign sym_tick = last_bit;

    assign push = in_valid && in_ready;
    assign pop  = load && !fifo_empty;

    lanes_sym_fifo #(.DW(2 * WIDTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({in_lane_1, in_lane_0}),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .ready   (in_ready)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_gen   = active_gen;
        case (state)
            ST_OFF: if (link_en) state_next = ST_START;
            ST_START: begin
                load       = 1'b1;
                load_gen   = gen_speed;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                load = last_bit;
                if (!link_en || gen_speed != active_gen) state_next = ST_DRAIN;
            end
            ST_DRAIN: if (last_bit) state_next = link_en ? ST_START : ST_OFF;
            default: state_next = ST_OFF;
        endcase
    end

    // Bits beyond the symbol length of the generation being loaded are forced to zero.
    always_comb begin
        sym_mask = '0;
        for (int i = 0; i < WIDTH; i++) sym_mask[i] = (i < int'(sym_len(load_gen)));
        next_0 = (fifo_empty ? IDLE_SYM[WIDTH-1:0] : head[WIDTH-1:0]) & sym_mask;
        next_1 = (fifo_empty ? IDLE_SYM[WIDTH-1:0] : head[2*WIDTH-1:WIDTH]) & sym_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_OFF;
            bit_cnt            <= 8'd0;
            active_gen         <= GEN3;
            enable_ser         <= 1'b0;
            enable_deser       <= 1'b0;
            gen_err            <= 1'b0;
            underrun_cnt       <= '0;
            lane_0_tx_parallel <= '0;
            lane_1_tx_parallel <= '0;
        end else begin
            state        <= state_next;
            enable_ser   <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            enable_deser <= enable_ser;

            if (counting && !last_bit) bit_cnt <= bit_cnt + 8'd1;
            else                       bit_cnt <= 8'd0;

            if (state == ST_START) begin
                active_gen <= gen_speed;
                if (gen_speed == GEN_RSVD) gen_err <= 1'b1;
            end

            if (load) begin
                lane_0_tx_parallel <= next_0;
                lane_1_tx_parallel <= next_1;
                // Idles inserted at the START load are not underruns.
                if (fifo_empty && state == ST_RUN && underrun_cnt != '1)
                    underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lanes_tx_rx_sched.sv
// Randomized bench for lanes_tx_rx_sched against a queue-based behavioural model.
// Outputs are compared every cycle on the falling edge.
module tb_lanes_tx_rx_sched;

    localparam int W  = 132;
    localparam int UW = 4;
    localparam int UNDER_MAX = (1 << UW) - 1;
    localparam logic [W-1:0] LO66 = {{66{1'b0}}, {66{1'b1}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          link_en;
    logic [1:0]    gen_speed;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_lane_0;
    logic [W-1:0]  in_lane_1;
    logic          enable_ser;
    logic          enable_deser;
    logic [W-1:0]  lane_0_tx_parallel;
    logic [W-1:0]  lane_1_tx_parallel;
    logic          sym_tick;
    logic [1:0]    active_gen;
    logic          gen_err;
    logic [UW-1:0] underrun_cnt;

    lanes_tx_rx_sched #(.WIDTH(W), .UNDERRUN_W(UW)) dut (
        .clk                (clk),
        .rst                (rst),
        .link_en            (link_en),
        .gen_speed          (gen_speed),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_lane_0          (in_lane_0),
        .in_lane_1          (in_lane_1),
        .enable_ser         (enable_ser),
        .enable_deser       (enable_deser),
        .lane_0_tx_parallel (lane_0_tx_parallel),
        .lane_1_tx_parallel (lane_1_tx_parallel),
        .sym_tick           (sym_tick),
        .active_gen         (active_gen),
        .gen_err            (gen_err),
        .underrun_cnt       (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Model: link phase (0 off, 1 start, 2 run, 3 drain), bit position, FIFO as a queue.
    typedef struct packed {
        logic [W-1:0] l0;
        logic [W-1:0] l1;
    } pair_t;

    pair_t        m_q[$];
    int           m_mode;
    int           m_pos;
    logic [1:0]   m_gen;
    logic [W-1:0] m_tx0;
    logic [W-1:0] m_tx1;
    bit           m_es;
    bit           m_ed;
    bit           m_err;
    int           m_und;
    bit           m_ready;

    function automatic int len_of(input logic [1:0] g);
        return (g == 2'b01) ? 66 : 132;
    endfunction

    task automatic model_step();
        int    nmode;
        bit    last;
        bit    do_load;
        bit    in_run;
        bit    pushing;
        pair_t s;
        logic [1:0] lgen;
        if (rst) begin
            m_q.delete();
            m_mode = 0; m_pos = 0; m_gen = 2'b10;
            m_tx0 = '0; m_tx1 = '0; m_es = 0; m_ed = 0;
            m_err = 0; m_und = 0; m_ready = 1;
            return;
        end
        pushing = in_valid && m_ready;
        last    = (m_mode >= 2) && (m_pos == len_of(m_gen) - 1);
        in_run  = (m_mode == 2);
        nmode   = m_mode;
        do_load = 0;
        lgen    = m_gen;
        case (m_mode)
            0: if (link_en) nmode = 1;
            1: begin
                do_load = 1;
                lgen    = gen_speed;
                nmode   = 2;
            end
            2: begin
                do_load = last;
                if (!link_en || gen_speed != m_gen) nmode = 3;
            end
            default: if (last) nmode = link_en ? 1 : 0;
        endcase
        if (do_load) begin
            if (m_q.size() > 0) begin
                s = m_q.pop_front();
            end else begin
                s = '0;
                if (in_run && m_und != UNDER_MAX) m_und++;
            end
            if (lgen == 2'b01) begin
                s.l0 = s.l0 & LO66;
                s.l1 = s.l1 & LO66;
            end
            m_tx0 = s.l0;
            m_tx1 = s.l1;
        end
        if (m_mode == 1) begin
            m_gen = gen_speed;
            if (gen_speed == 2'b11) m_err = 1;
        end
        if (pushing) m_q.push_back('{l0: in_lane_0, l1: in_lane_1});
        m_ready = (m_q.size() < 2);
        m_pos   = (m_mode >= 2 && !last) ? m_pos + 1 : 0;
        m_ed    = m_es;
        m_es    = (nmode == 2 || nmode == 3);
        m_mode  = nmode;
    endtask

    task automatic compare();
        bit exp_tick;
        exp_tick = (m_mode >= 2) && (m_pos == len_of(m_gen) - 1);
        check("in_ready",     W'(in_ready),     W'(m_ready));
        check("enable_ser",   W'(enable_ser),   W'(m_es));
        check("enable_deser", W'(enable_deser), W'(m_ed));
        check("sym_tick",     W'(sym_tick),     W'(exp_tick));
        check("active_gen",   W'(active_gen),   W'(m_gen));
        check("gen_err",      W'(gen_err),      W'(m_err));
        check("underrun_cnt", W'(underrun_cnt), W'(m_und));
        check("lane_0_tx",    lane_0_tx_parallel, m_tx0);
        check("lane_1_tx",    lane_1_tx_parallel, m_tx1);
    endtask

    function automatic logic [W-1:0] rnd_sym();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic cycle(input logic r, input logic le, input logic [1:0] gs, input logic v);
        @(negedge clk);
        compare();
        rst       = r;
        link_en   = le;
        gen_speed = gs;
        in_valid  = v;
        in_lane_0 = rnd_sym();
        in_lane_1 = rnd_sym();
        model_step();
    endtask

    initial begin
        logic       le;
        logic [1:0] gs;
        rst = 1'b1; link_en = 1'b0; gen_speed = 2'b10; in_valid = 1'b0;
        in_lane_0 = '0; in_lane_1 = '0;
        model_step();
        repeat (3) cycle(1'b1, 1'b0, 2'b10, 1'b0);

        // Gen3: two back-to-back symbols fill the FIFO, a third is held off, then starve.
        cycle(1'b0, 1'b0, 2'b10, 1'b1);
        cycle(1'b0, 1'b0, 2'b10, 1'b1);
        cycle(1'b0, 1'b0, 2'b10, 1'b1);
        cycle(1'b0, 1'b1, 2'b10, 1'b0);
        repeat (600) cycle(1'b0, 1'b1, 2'b10, 1'b0);

        // Switch to Gen2 mid-symbol; sparse traffic drives the underrun counter to saturation.
        repeat (2500) cycle(1'b0, 1'b1, 2'b01, ($urandom_range(79) == 0));

        // Stop the link mid-symbol with traffic pending, then resume.
        repeat (40) cycle(1'b0, 1'b1, 2'b10, 1'b0);
        repeat (300) cycle(1'b0, 1'b0, 2'b10, 1'b1);
        repeat (400) cycle(1'b0, 1'b1, 2'b10, 1'b0);

        // Random link toggles, speed changes (reserved included) and occasional resets.
        le = 1'b1;
        gs = 2'b10;
        for (int i = 0; i < 9000; i++) begin
            if ($urandom_range(399) == 0) le = ~le;
            if ($urandom_range(499) == 0) gs = 2'($urandom_range(3));
            cycle(($urandom_range(2999) == 0), le, gs, ($urandom_range(39) == 0));
        end

        // Reset in the middle of a running Gen3 symbol.
        repeat (3) cycle(1'b1, 1'b0, 2'b10, 1'b0);
        repeat (150) cycle(1'b0, 1'b1, 2'b10, ($urandom_range(3) == 0));
        cycle(1'b1, 1'b1, 2'b10, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 2'b10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lanes_tx_rx_sched.md
# lanes_tx_rx_sched

Symbol scheduler and enable sequencer for the two-lane serializer/deserializer pair. Accepts 2-lane parallel symbols from the encoder through a valid/ready handshake, buffers them in a 2-entry FIFO, and presents them to the serializer exactly at symbol boundaries for the current generation. Controls the serializer and deserializer enables, inserts idle symbols on underrun, and performs a clean drain/restart when the link is disabled or `gen_speed` changes.

## Interface
- `WIDTH`, 132: parallel symbol width per lane (max symbol length).
- `UNDERRUN_W`, 16: width of the saturating underrun counter.
- `clk`  in  1: single clock, one serial bit per lane per cycle.
- `rst`  in  1: reset is synchronous and active-high.
- `link_en`  in  1: level; 1 = run link, 0 = drain and stop.
- `gen_speed`  in  2: 2'b01 Gen2, 2'b10 Gen3, 2'b00 Gen4, 2'b11 reserved.
- `in_valid`  in  1: upstream symbol pair valid.
- `in_ready`  out  1: FIFO can accept; registered, equals FIFO not full.
- `in_lane_0`, `in_lane_1`  in  WIDTH: upstream symbols.
- `enable_ser`  out  1: serializer enable.
- `enable_deser`  out  1: deserializer enable.
- `lane_0_tx_parallel`, `lane_1_tx_parallel`  out  WIDTH: symbols to serializer.
- `sym_tick`  out  1: one-cycle pulse on the last bit cycle of each symbol.
- `active_gen`  out  2: generation latched for the current run.
- `gen_err`  out  1: sticky; set when reserved speed latched; cleared by `rst`.
- `underrun_cnt`  out  UNDERRUN_W: idle symbols inserted, saturating.

## Operation
- Symbol length SYM_LEN: Gen2 66, Gen3 132, Gen4 132, reserved 132 (and sets `gen_err`). For Gen2 bits [WIDTH-1:66] of tx outputs are driven 0.
- FSM states: OFF, START, RUN, DRAIN.
- OFF: enables 0, bit counter 0. `link_en`=1 -> START.
- START (1 cycle): latch `gen_speed` into `active_gen`; load tx outputs from FIFO head (pop) or IDLE_SYM if empty; -> RUN. `enable_ser` rises on the START->RUN edge.
- RUN: bit_cnt counts 0..SYM_LEN-1, wraps. On bit_cnt==SYM_LEN-1: `sym_tick`=1 and tx outputs load next symbol (pop FIFO, or IDLE_SYM and `underrun_cnt`+1 if empty). If `link_en`=0 or `gen_speed`!=`active_gen` -> DRAIN.
- DRAIN: continue counting to end of current symbol with no new load; at SYM_LEN-1 -> OFF if `link_en`=0, else -> START (restart with new speed). FIFO contents retained across restart.
- `enable_deser` = 1 in RUN and DRAIN, registered (asserted one cycle after `enable_ser`).
- FIFO: 2 entries; push when `in_valid`&&`in_ready`; pop only at symbol load points; simultaneous push and pop when 1 entry allowed. Pushes accepted in every state.
- IDLE_SYM = all zeros (package constant).

## Timing
- Reset values: `enable_ser`/`enable_deser`/`sym_tick`/`gen_err` 0, tx outputs 0, `underrun_cnt` 0, `active_gen` 2'b10, `in_ready` 1, FIFO empty, state OFF.
- `rst` mid-operation: all of the above at next edge; buffered data discarded.
- Latency: symbol pushed into empty FIFO during RUN appears on tx outputs the cycle after the next `sym_tick`.
- tx outputs stable for exactly SYM_LEN cycles per symbol in RUN.
- `in_ready` reflects occupancy after the current edge; full FIFO with same-cycle pop still shows `in_ready`=0 that cycle.
- `link_en` toggled back to 1 during DRAIN: DRAIN completes, then START.
- `underrun_cnt` saturates at all-ones.

## Structure
- Package `lanes_sched_pkg`: state enum, gen encodings, SYM_LEN constants per gen, IDLE_SYM.
- Sub-module `lanes_sym_fifo` (2-entry, parameterized width 2*WIDTH); FSM/counter in top.

## Test plan
- Gen3, link_en=1, push A,B back-to-back -> START loads A, `sym_tick` at cycles 132 and 264 of RUN, B follows A, then IDLE_SYM with `underrun_cnt`=1.
- Gen2 -> symbol period 66 cycles, upper 66 tx bits 0.
- No data for 3 symbols -> `underrun_cnt`=3; preload to max-1, 2 more underruns -> stays all-ones.
- Change gen_speed 10->01 mid-symbol at bit 40 -> symbol completes at bit 131, START, `active_gen`=01, 66-cycle period.
- link_en=0 at bit 10 -> enables drop after bit 131; FIFO retained, resumes on link_en=1.
- Fill FIFO (2) with no pop -> `in_ready`=0, 3rd valid held off; `rst` mid-RUN -> all reset values next cycle.
